cfg_chain_loader: RTL and testbench

//  Bitstream loader directly upstream of the connection-box/switch-box config shift chains.

---
 rtl/cfg_chain_loader.sv | 215 +++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader
//   Bitstream loader sitting directly in front of the connection-box/switch-box
//   configuration shift chains. Config words arrive on a valid/ready stream and
//   are serialised into two chains (A and B) that shift in parallel, one bit
//   pair per cycle. While a load is in progress the fabric is held in config
//   mode. After the last data word an XOR checksum word is compared, then a
//   one-cycle done pulse is issued and err reflects the checksum result.
//
// Parameters
//   WORD_W    : input word width, must be even; WORD_W/2 (A,B) pairs per word
//   CHAIN_LEN : bits per chain (A and B have equal length), >= 1
//
// Ports
//   clk        : clock
//   nrst       : asynchronous active-low reset
//   start      : begin a load (only looked at while idle)
//   abort      : cancel the load in progress, back to idle next cycle
//   in_data    : config word; bit 2k -> chain A, bit 2k+1 -> chain B, LSB pair first
//   in_valid   : in_data valid
//   in_ready   : loader accepts in_data this cycle
//   cfg_active : fabric config_en, high for the whole load session
//   shift_en   : fabric shift enable, high exactly on cycles a bit pair shifts
//   cfg_bit_a  : serial bit into chain A head
//   cfg_bit_b  : serial bit into chain B head
//   busy       : loader is not idle
//   done       : one-cycle pulse when a load completes (checksum good or bad)
//   err        : sticky checksum mismatch, cleared by the next accepted start
// -----------------------------------------------------------------------------
module cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 40
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_active,
    output logic              shift_en,
    output logic              cfg_bit_a,
    output logic              cfg_bit_b,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PAIRS  = WORD_W / 2;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int PIDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [PIDX_W-1:0] LAST_PAIR = PIDX_W'(PAIRS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nx;

    logic [WORD_W-1:0]   shreg;     // word being serialised, LSB pair at [1:0]
    logic [WORD_W-1:0]   chk;       // running XOR of accepted data words
    logic [CNT_W-1:0]    bitcnt;    // pairs shifted so far in this load
    logic [PIDX_W-1:0]   pidx;      // pair index within the current word
    logic                err_q;

    logic                last_bit;
    logic                last_pair;
    logic                xfer;

    assign last_bit  = (bitcnt == LAST_BIT);
    assign last_pair = (pidx == LAST_PAIR);

    // A word only moves when the loader is ready and the load is not being
    // cancelled in the same cycle; abort wins over a coincident handshake.
    assign xfer = in_valid && in_ready && !abort;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and output decode. Every output is a function of the
    // registered state and shift register only, never of an input.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        cfg_active = 1'b0;
        shift_en   = 1'b0;
        cfg_bit_a  = 1'b0;
        cfg_bit_b  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = S_FETCH;
                end
            end

            S_FETCH: begin
                in_ready   = 1'b1;
                cfg_active = 1'b1;
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (in_valid) begin
                    state_nx = S_SHIFT;
                end
            end

            S_SHIFT: begin
                cfg_active = 1'b1;
                shift_en   = 1'b1;
                cfg_bit_a  = shreg[0];
                cfg_bit_b  = shreg[1];
                // The pair presented this cycle shifts into the fabric even if
                // abort is raised now: the chain keeps whatever was shifted.
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (last_bit) begin
                    // Chain full; any remaining pairs of this word are dropped.
                    state_nx = S_CHECK;
                end else if (last_pair) begin
                    state_nx = S_FETCH;
                end
            end

            S_CHECK: begin
                in_ready   = 1'b1;
                cfg_active = 1'b1;
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (in_valid) begin
                    state_nx = S_DONE;
                end
            end

            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, checksum, counters, sticky error
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shreg  <= '0;
            chk    <= '0;
            bitcnt <= '0;
            pidx   <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        chk    <= '0;
                        bitcnt <= '0;
                        pidx   <= '0;
                        err_q  <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (xfer) begin
                        shreg <= in_data;
                        chk   <= chk ^ in_data;
                        pidx  <= '0;
                    end
                end

                S_SHIFT: begin
                    shreg  <= shreg >> 2;
                    bitcnt <= bitcnt + 1'b1;
                    pidx   <= pidx + 1'b1;
                end

                S_CHECK: begin
                    if (xfer) begin
                        err_q <= (in_data != chk);
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
module tb_cfg_chain_loader;

    logic       clk;
    logic       nrst;

    // 10-bit chain instance (chain length not a multiple of the pair count)
    logic       start, abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, cfg_active, shift_en, cfg_bit_a, cfg_bit_b, busy, done, err;

    // 8-bit chain instance
    logic       start8, abort8, in_valid8;
    logic [7:0] in_data8;
    logic       in_ready8, cfg_active8, shift_en8, cfg_bit_a8, cfg_bit_b8, busy8, done8, err8;

    int n_chk  = 0;
    int n_fail = 0;

    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(10)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_active(cfg_active), .shift_en(shift_en),
        .cfg_bit_a(cfg_bit_a), .cfg_bit_b(cfg_bit_b),
        .busy(busy), .done(done), .err(err)
    );

    cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(8)) dut8 (
        .clk(clk), .nrst(nrst), .start(start8), .abort(abort8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .cfg_active(cfg_active8), .shift_en(shift_en8),
        .cfg_bit_a(cfg_bit_a8), .cfg_bit_b(cfg_bit_b8),
        .busy(busy8), .done(done8), .err(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- observers (sampled on the falling edge) ----------------
    logic qa[$];
    logic qb[$];
    int   n_done = 0;
    int   n_busy = 0;
    int   mon_err = 0;

    always @(negedge clk) begin
        if (shift_en) begin
            qa.push_back(cfg_bit_a);
            qb.push_back(cfg_bit_b);
        end
        if (done)  n_done <= n_done + 1;
        if (busy)  n_busy <= n_busy + 1;
        // fabric must be in config mode whenever it shifts; never ready while shifting
        if ((shift_en && !cfg_active) || (shift_en && in_ready) || (done && cfg_active))
            mon_err <= mon_err + 1;
    end

    logic [15:0] a8v = '0;
    logic [15:0] b8v = '0;
    int          n8 = 0;
    int          rdy8 = 0;
    int          done8_n = 0;

    always @(negedge clk) begin
        if (shift_en8) begin
            if (n8 < 16) begin
                a8v[n8] <= cfg_bit_a8;
                b8v[n8] <= cfg_bit_b8;
            end
            n8 <= n8 + 1;
        end
        if (in_ready8) rdy8 <= rdy8 + 1;
        if (done8)     done8_n <= done8_n + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] w0, w1, w2, ck;
        int         gap;
        logic [9:0] ea, eb;
        logic       ee;
    } vec_t;

    // Reference: shift i carries pair (i mod 4) of word (i div 4); A is the
    // even bit of the pair, B the odd bit. Only the first 10 pairs are used.
    function automatic logic [9:0] model_bits(input vec_t v, input int b);
        logic [7:0] ws [3];
        logic [9:0] m;
        ws = '{v.w0, v.w1, v.w2};
        m = '0;
        for (int i = 0; i < 10; i++) m[i] = ws[i / 4][2 * (i % 4) + b];
        return m;
    endfunction

    // One complete load on the 10-bit instance, with 'gap' idle cycles of
    // in_valid=0 in front of every word once the loader is waiting for it.
    task automatic run_load(input string nm, input vec_t v);
        logic [7:0] ws [4];
        int         b0, d0, y0;
        logic       hs, ok;
        logic [9:0] ga, gb;
        ws = '{v.w0, v.w1, v.w2, v.ck};
        b0 = qa.size(); d0 = n_done; y0 = n_busy;
        if (v.gap == 0) begin in_valid = 1'b1; in_data = ws[0]; end
        else            in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({nm, " err_clr"}, 32'(err), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (v.gap > 0) begin
                ok = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    if (in_ready) begin ok = 1'b1; break; end
                    @(posedge clk); #1;
                end
                check({nm, " ready_wait"}, 32'(ok), 32'd1);
                for (int g = 0; g < v.gap; g++) begin
                    @(posedge clk); #1;
                    check({nm, " stall"}, {30'd0, in_ready, shift_en}, 32'b10);
                end
                in_valid = 1'b1; in_data = ws[k];
            end
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                hs = in_ready;
                @(posedge clk); #1;
                if (hs) begin ok = 1'b1; break; end
            end
            check({nm, " handshake"}, 32'(ok), 32'd1);
            if (v.gap > 0)  in_valid = 1'b0;
            else if (k < 3) in_data = ws[k + 1];
        end
        in_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        check({nm, " finish"}, 32'(ok), 32'd1);
        ga = '0; gb = '0;
        for (int i = 0; i < 10 && b0 + i < qa.size(); i++) begin
            ga[i] = qa[b0 + i];
            gb[i] = qb[b0 + i];
        end
        check({nm, " shifts"}, 32'(qa.size() - b0), 32'd10);
        check({nm, " bits_a"}, 32'(ga), 32'(v.ea));
        check({nm, " bits_b"}, 32'(gb), 32'(v.eb));
        check({nm, " done"}, 32'(n_done - d0), 32'd1);
        check({nm, " err"}, 32'(err), 32'(v.ee));
        check({nm, " cycles"}, 32'(n_busy - y0), 32'(15 + 4 * v.gap));
        check({nm, " monitor"}, 32'(mon_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t tbl [4];
        vec_t v;
        int   s, b0, d0;
        logic ok, hs, bad, e0;
        logic [7:0] w8 [3];

        tbl[0] = '{8'hA5, 8'h3C, 8'h0F, 8'h96, 0, 10'h363, 10'h36C, 1'b0};
        tbl[1] = '{8'hA5, 8'h3C, 8'h0F, 8'h97, 0, 10'h363, 10'h36C, 1'b1};
        tbl[2] = '{8'hA5, 8'h3C, 8'h0F, 8'h96, 3, 10'h363, 10'h36C, 1'b0};
        tbl[3] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 1, 10'h30F, 10'h00F, 1'b0};

        nrst = 1'b0;
        start = 0; abort = 0; in_valid = 0; in_data = '0;
        start8 = 0; abort8 = 0; in_valid8 = 0; in_data8 = '0;
        #3;
        check("reset outs", {24'd0, in_ready, cfg_active, shift_en, cfg_bit_a, cfg_bit_b, busy, done, err}, 32'd0);
        check("reset outs8", {24'd0, in_ready8, cfg_active8, shift_en8, cfg_bit_a8, cfg_bit_b8, busy8, done8, err8}, 32'd0);
        @(posedge clk); #1 nrst = 1'b1;
        @(posedge clk); #1;

        // directed table: good load, bad checksum, stalled load, second pattern
        for (int t = 0; t < 4; t++) begin
            run_load($sformatf("vec%0d", t), tbl[t]);
            repeat (3) @(posedge clk);
            #1 check($sformatf("vec%0d err_hold", t), 32'(err), 32'(tbl[t].ee));
        end

        // abort during the 6th shift
        b0 = qa.size(); d0 = n_done;
        in_valid = 1'b1; in_data = 8'hA5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        s = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (shift_en) s++;
            if (s == 6) break;
        end
        check("abort reach6", 32'(s), 32'd6);
        e0 = err;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
        check("abort idle", {28'd0, busy, cfg_active, shift_en, in_ready}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort shifts", 32'(qa.size() - b0), 32'd6);
        check("abort nodone", 32'(n_done - d0), 32'd0);
        check("abort err", 32'(err), 32'(e0));

        // abort coincident with a handshake: word not consumed, nothing shifts
        b0 = qa.size();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("abort_hs ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'hFF; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_hs busy", 32'(busy), 32'd0);
        check("abort_hs shifts", 32'(qa.size() - b0), 32'd0);

        // asynchronous reset while shifting, then a full reload
        in_valid = 1'b1; in_data = 8'hA5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (shift_en) begin ok = 1'b1; break; end
        end
        check("rst reach_shift", 32'(ok), 32'd1);
        #2 nrst = 1'b0;
        #1 check("rst async outs", {24'd0, in_ready, cfg_active, shift_en, cfg_bit_a, cfg_bit_b, busy, done, err}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1 nrst = 1'b1;
        @(posedge clk); #1;
        run_load("reload", tbl[0]);

        // randomized loads against the reference model
        for (int r = 0; r < 16; r++) begin
            v.w0 = 8'($urandom); v.w1 = 8'($urandom); v.w2 = 8'($urandom);
            v.gap = int'($urandom_range(0, 2));
            bad = 1'($urandom_range(0, 1));
            v.ck = v.w0 ^ v.w1 ^ v.w2 ^ (bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            v.ee = bad;
            v.ea = model_bits(v, 0);
            v.eb = model_bits(v, 1);
            run_load($sformatf("rnd%0d", r), v);
        end

        // 8-bit chain: exact word fit, start pulsed while busy
        w8 = '{8'hFF, 8'h00, 8'hFF};
        in_valid8 = 1'b1; in_data8 = w8[0]; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data8 = w8[k];
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                hs = in_ready8;
                @(posedge clk); #1 start8 = 1'b0;
                if (hs) begin ok = 1'b1; break; end
            end
            check($sformatf("c8 handshake%0d", k), 32'(ok), 32'd1);
            if (k == 0) start8 = 1'b1;
        end
        in_valid8 = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (!busy8) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("c8 finish", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("c8 still_idle", 32'(busy8), 32'd0);
        check("c8 shifts", 32'(n8), 32'd8);
        check("c8 bits_a", 32'(a8v), 32'h0F);
        check("c8 bits_b", 32'(b8v), 32'h0F);
        check("c8 ready_cycles", 32'(rdy8), 32'd3);
        check("c8 done", 32'(done8_n), 32'd1);
        check("c8 err", 32'(err8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
